// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional two-entry skid buffer,
// bubble-as-NOP control zeroing and saturating bubble/flush performance counters.
module pipe_stage_skid_reg #(
    parameter int CTRL_W              = 16,
    parameter int DATA_W              = 128,
    parameter int SKID                = 1,
    parameter int CLEAR_DATA_ON_FLUSH = 1,
    parameter int CNT_W               = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              any_valid;
    logic              in_fire;

    assign in_fire = in_valid && in_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              s_valid;
            logic [CTRL_W-1:0] s_ctrl;
            logic [DATA_W-1:0] s_data;

            // Ready depends only on registered state, so out_ready never reaches upstream.
            assign in_ready  = !s_valid || reset;
            assign any_valid = m_valid || s_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    m_data  <= '0;
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                    s_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    s_valid <= 1'b0;
                    s_ctrl  <= '0;
                    if (CLEAR_DATA_ON_FLUSH != 0) begin
                        m_data <= '0;
                        s_data <= '0;
                    end
                end else if (!m_valid || out_ready) begin
                    if (s_valid) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= s_ctrl;
                        m_data  <= s_data;
                        s_valid <= 1'b0;
                        s_ctrl  <= '0;
                    end else if (in_fire) begin
                        m_valid <= 1'b1;
                        m_ctrl  <= in_ctrl;
                        m_data  <= in_data;
                    end else begin
                        m_valid <= 1'b0;
                        m_ctrl  <= '0;
                    end
                end else if (in_fire) begin
                    // Main is stalled; park the accepted entry behind it.
                    s_valid <= 1'b1;
                    s_ctrl  <= in_ctrl;
                    s_data  <= in_data;
                end
            end
        end else begin : g_pass
            logic out_fire;

            assign in_ready  = !m_valid || out_ready;
            assign any_valid = m_valid;
            assign out_fire  = m_valid && out_ready;

            always_ff @(posedge clk) begin
                if (reset) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                    if (CLEAR_DATA_ON_FLUSH != 0) begin
                        m_data <= '0;
                    end
                end else if (in_fire) begin
                    m_valid <= 1'b1;
                    m_ctrl  <= in_ctrl;
                    m_data  <= in_data;
                end else if (out_fire) begin
                    m_valid <= 1'b0;
                    m_ctrl  <= '0;
                end
            end
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (!m_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (flush && any_valid && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
